// File: rtl/uart_fifo_tx_if.sv
// FIFO read-side and UART line signals of the serialiser, bundled as one port.
interface uart_fifo_tx_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  enable;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_en;
    logic                  tx;
    logic                  busy;
    logic                  frame_done;

    modport master (
        input  enable, fifo_empty, fifo_data,
        output fifo_rd_en, tx, busy, frame_done
    );

    modport slave (
        output enable, fifo_empty, fifo_data,
        input  fifo_rd_en, tx, busy, frame_done
    );
endinterface

// File: rtl/uart_fifo_tx.sv
// Pops one word per frame from the FIFO and shifts it out as start/data/parity/stop bits.
// Start bit begins 3 cycles after IDLE sees non-empty; fetching is held off by !enable or empty.
module uart_fifo_tx #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic           clk,
    input  logic           rst,
    uart_fifo_tx_if.master bus
);
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  parity_bit;

    logic bit_end;
    logic last_data;
    logic last_stop;

    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign last_data = (bit_cnt == DATA_LAST);
    assign last_stop = (bit_cnt == STOP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (bus.enable && !bus.fifo_empty) state_nxt = FETCH;
            FETCH:  state_nxt = LOAD;
            LOAD:   state_nxt = START;
            START:  if (bit_end) state_nxt = DATA;
            DATA: begin
                if (bit_end && last_data) begin
                    state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: if (bit_end) state_nxt = STOP;
            STOP:   if (bit_end && last_stop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // bit_cnt counts data bits in DATA and stop bits in STOP; it is zero on entry to both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    shift_reg  <= bus.fifo_data;
                    parity_bit <= (^bus.fifo_data) ^ 1'(PARITY_ODD);
                    baud_cnt   <= '0;
                    bit_cnt    <= '0;
                end
                START, PARITY: begin
                    baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt  <= '0;
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= last_data ? '0 : bit_cnt + 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= bit_cnt + 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.tx         = 1'b1;
        bus.fifo_rd_en = 1'b0;
        bus.busy       = (state != IDLE);
        bus.frame_done = 1'b0;
        case (state)
            FETCH:  bus.fifo_rd_en = 1'b1;
            START:  bus.tx = 1'b0;
            DATA:   bus.tx = shift_reg[0];
            PARITY: bus.tx = parity_bit;
            STOP:   bus.frame_done = bit_end && last_stop;
            default: bus.tx = 1'b1;
        endcase
    end
endmodule
